// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A clock divider produces a
//   pixel tick. Horizontal and vertical counters advance on that tick, and
//   the sync/blank decode is registered together with the counters, so all
//   outputs describe the same pixel. A programmable-depth delayed copy of
//   the syncs and video_on lets downstream pixel pipelines match latency.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   enable      1 = run, 0 = freeze divider, counters and all outputs
//   p_tick      one-clk pixel strobe
//   pixel_x/y   current horizontal / vertical position
//   video_on    pixel is inside the visible area
//   hsync/vsync sync outputs, active level HS_POL / VS_POL
//   line_tick   one-clk pulse on the first clk of a new line
//   frame_tick  one-clk pulse on the first clk of a new frame
//   frame_cnt   frames completed, modulo 2^16
//   *_d         hsync/vsync/video_on delayed by PIPE_DLY pixel ticks

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int CNT_W    = 10,
    parameter int PIPE_DLY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_tick,
    output logic             frame_tick,
    output logic [15:0]      frame_cnt,
    output logic             hsync_d,
    output logic             vsync_d,
    output logic             video_on_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             tick_q;
    logic             line_q;
    logic             frame_q;
    logic             advance;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    // pixel_x/pixel_y double as the raster counters: both would load h_next/v_next
    // on every enabled clk and share the same reset value.
    always_comb begin
        advance  = enable & tick_q;
        h_wrap   = (pixel_x == H_LAST);
        v_wrap   = (pixel_y == V_LAST);
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
        h_next   = pixel_x;
        v_next   = pixel_y;
        if (advance) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : pixel_y + 1'b1;
            end else begin
                h_next = pixel_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            tick_q    <= 1'b0;
            pixel_x   <= '0;
            pixel_y   <= '0;
            video_on  <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            frame_cnt <= '0;
        end else if (enable) begin
            div       <= div_next;
            tick_q    <= (div == DIV_LAST);
            pixel_x   <= h_next;
            pixel_y   <= v_next;
            video_on  <= (h_next < H_VIS) && (v_next < V_VIS);
            hsync     <= (h_next >= HS_START && h_next <= HS_END) ? HS_POL : ~HS_POL;
            vsync     <= (v_next >= VS_START && v_next <= VS_END) ? VS_POL : ~VS_POL;
            line_q    <= advance & h_wrap;
            frame_q   <= advance & h_wrap & v_wrap;
            if (advance && h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Strobes are forced low while frozen; the held registers resume on enable.
    assign p_tick     = tick_q  & enable;
    assign line_tick  = line_q  & enable;
    assign frame_tick = frame_q & enable;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hsync_d    = hsync;
            assign vsync_d    = vsync;
            assign video_on_d = video_on;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe;
            logic [PIPE_DLY-1:0] vs_pipe;
            logic [PIPE_DLY-1:0] vo_pipe;

            // Stage 0 samples the registered outputs before the tick edge updates
            // them, so each stage is exactly one pixel tick older than the last.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hs_pipe <= {PIPE_DLY{~HS_POL}};
                    vs_pipe <= {PIPE_DLY{~VS_POL}};
                    vo_pipe <= '0;
                end else if (advance) begin
                    hs_pipe <= (hs_pipe << 1) | PIPE_DLY'(hsync);
                    vs_pipe <= (vs_pipe << 1) | PIPE_DLY'(vsync);
                    vo_pipe <= (vo_pipe << 1) | PIPE_DLY'(video_on);
                end
            end

            assign hsync_d    = hs_pipe[PIPE_DLY-1];
            assign vsync_d    = vs_pipe[PIPE_DLY-1];
            assign video_on_d = vo_pipe[PIPE_DLY-1];
        end
    endgenerate

endmodule
